// File: rtl/pong_engine.sv
// Pong game-state engine: ball, paddles, bounces, goals and score, advanced once per frame_tick.
// All outputs are registered so the renderer sees a stable state for the whole frame.
module pong_engine #(
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_H     = 48,
    parameter int PADDLE_STEP  = 4,
    parameter int BALL_SPEED   = 2,
    parameter int WIN_SCORE    = 3,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       dclk,
    input  logic       clr_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       up_l,
    input  logic       dn_l,
    input  logic       up_r,
    input  logic       dn_r,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle_l_y,
    output logic [9:0] paddle_r_y,
    output logic [1:0] score_l,
    output logic [1:0] score_r,
    output logic       game_over
);

    localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

    localparam logic [10:0] ARENA_L = 11'd50;
    localparam logic [10:0] ARENA_T = 11'd50;
    localparam logic [10:0] ARENA_B = 11'd430;
    localparam logic [10:0] GOAL_R  = 11'd590;
    localparam logic [10:0] PAD_LX  = 11'd60;
    localparam logic [10:0] PAD_RX  = 11'd580;
    localparam logic [10:0] SZ      = 11'(BALL_SIZE);
    localparam logic [10:0] SPD     = 11'(BALL_SPEED);
    localparam logic [10:0] PH      = 11'(PADDLE_H);
    localparam logic [10:0] STEP    = 11'(PADDLE_STEP);

    localparam logic [9:0] CX = 10'(320 - BALL_SIZE / 2);
    localparam logic [9:0] CY = 10'(240 - BALL_SIZE / 2);
    localparam logic [9:0] CP = 10'(240 - PADDLE_H / 2);

    typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_t;

    state_t        state;
    logic          dx, dy;
    logic          point_l;
    logic [CW-1:0] serve_cnt;

    logic [10:0] x11, y11, pl11, pr11;
    logic [9:0]  nx, ny;
    logic        dy_n, ovl_l, ovl_r, hit_l, hit_r, goal_l, goal_r;
    logic [9:0]  pl_n, pr_n;
    logic [1:0]  sl_inc, sr_inc;

    function automatic logic [9:0] paddle_move(input logic [9:0] y, input logic up, input logic dn);
        logic [10:0] yy;
        yy = {1'b0, y};
        if (up && !dn)
            return (yy < ARENA_T + STEP) ? ARENA_T[9:0] : 10'(yy - STEP);
        else if (dn && !up)
            return (yy + STEP > ARENA_B - PH) ? 10'(ARENA_B - PH) : 10'(yy + STEP);
        else
            return y;
    endfunction

    always_comb begin
        x11  = {1'b0, ball_x};
        y11  = {1'b0, ball_y};
        pl11 = {1'b0, paddle_l_y};
        pr11 = {1'b0, paddle_r_y};
        dy_n = dy;
        // Wall checks compare before moving so an upward step never wraps below zero.
        if (!dy) begin
            if (y11 < ARENA_T + SPD) begin
                ny   = ARENA_T[9:0];
                dy_n = 1'b1;
            end else begin
                ny = 10'(y11 - SPD);
            end
        end else begin
            if (y11 + SZ + SPD > ARENA_B) begin
                ny   = 10'(ARENA_B - SZ);
                dy_n = 1'b0;
            end else begin
                ny = 10'(y11 + SPD);
            end
        end
        ovl_l  = ({1'b0, ny} + SZ > pl11) && ({1'b0, ny} < pl11 + PH);
        ovl_r  = ({1'b0, ny} + SZ > pr11) && ({1'b0, ny} < pr11 + PH);
        hit_l  = !dx && (x11 >= PAD_LX) && (x11 < PAD_LX + SPD) && ovl_l;
        hit_r  = dx && (x11 + SZ <= PAD_RX) && (x11 + SZ + SPD > PAD_RX) && ovl_r;
        goal_r = !dx && (x11 < ARENA_L + SPD);
        goal_l = dx && (x11 + SZ + SPD > GOAL_R);
        if (hit_l)
            nx = PAD_LX[9:0];
        else if (hit_r)
            nx = 10'(PAD_RX - SZ);
        else if (dx)
            nx = 10'(x11 + SPD);
        else
            nx = 10'(x11 - SPD);
        pl_n   = paddle_move(paddle_l_y, up_l, dn_l);
        pr_n   = paddle_move(paddle_r_y, up_r, dn_r);
        sl_inc = score_l + 2'd1;
        sr_inc = score_r + 2'd1;
    end

    always_ff @(posedge dclk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            ball_x     <= CX;
            ball_y     <= CY;
            paddle_l_y <= CP;
            paddle_r_y <= CP;
            score_l    <= '0;
            score_r    <= '0;
            game_over  <= 1'b0;
            dx         <= 1'b1;
            dy         <= 1'b1;
            point_l    <= 1'b0;
            serve_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start)
                        state <= SERVE;
                end
                SERVE: begin
                    if (frame_tick) begin
                        paddle_l_y <= pl_n;
                        paddle_r_y <= pr_n;
                        if (serve_cnt == CW'(SERVE_FRAMES - 1)) begin
                            serve_cnt <= '0;
                            state     <= PLAY;
                        end else begin
                            serve_cnt <= serve_cnt + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (frame_tick) begin
                        paddle_l_y <= pl_n;
                        paddle_r_y <= pr_n;
                        dy         <= dy_n;
                        // A wall bounce still flips dy on a goal tick; only the position is frozen.
                        if (hit_l || hit_r) begin
                            ball_x <= nx;
                            ball_y <= ny;
                            dx     <= ~dx;
                        end else if (goal_l || goal_r) begin
                            point_l <= goal_l;
                            state   <= POINT;
                        end else begin
                            ball_x <= nx;
                            ball_y <= ny;
                        end
                    end
                end
                POINT: begin
                    if (point_l) begin
                        score_l <= sl_inc;
                        dx      <= 1'b1;
                    end else begin
                        score_r <= sr_inc;
                        dx      <= 1'b0;
                    end
                    if ((point_l ? sl_inc : sr_inc) == 2'(WIN_SCORE)) begin
                        dx        <= dx;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        ball_x <= CX;
                        ball_y <= CY;
                        state  <= SERVE;
                    end
                end
                OVER: begin
                    if (start) begin
                        score_l    <= '0;
                        score_r    <= '0;
                        ball_x     <= CX;
                        ball_y     <= CY;
                        paddle_l_y <= CP;
                        paddle_r_y <= CP;
                        dx         <= 1'b1;
                        game_over  <= 1'b0;
                        state      <= SERVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_engine.sv
// Bench for pong_engine: directed scenarios plus randomized play, every cycle compared
// against an integer game model written from the game rules.
module tb_pong_engine;

    logic       dclk = 1'b0;
    logic       clr_n = 1'b0;
    logic       frame_tick = 1'b0, start = 1'b0;
    logic       up_l = 1'b0, dn_l = 1'b0, up_r = 1'b0, dn_r = 1'b0;
    logic [9:0] ball_x, ball_y, paddle_l_y, paddle_r_y;
    logic [1:0] score_l, score_r;
    logic       game_over;

    pong_engine #(
        .BALL_SIZE   (8),
        .PADDLE_H    (48),
        .PADDLE_STEP (4),
        .BALL_SPEED  (2),
        .WIN_SCORE   (3),
        .SERVE_FRAMES(60)
    ) dut (
        .dclk      (dclk),
        .clr_n     (clr_n),
        .frame_tick(frame_tick),
        .start     (start),
        .up_l      (up_l),
        .dn_l      (dn_l),
        .up_r      (up_r),
        .dn_r      (dn_r),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .paddle_l_y(paddle_l_y),
        .paddle_r_y(paddle_r_y),
        .score_l   (score_l),
        .score_r   (score_r),
        .game_over (game_over)
    );

    always #5 dclk = ~dclk;

    int checks = 0;
    int failures = 0;
    int games = 0;

    // Model: phase 0 idle, 1 serve, 2 play, 3 point, 4 over
    int m_ph, bx, by, pl, pr, sl, sr, vx, vy, cnt;
    bit left_scored;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("ball_x", 32'(ball_x), bx);
        check("ball_y", 32'(ball_y), by);
        check("paddle_l_y", 32'(paddle_l_y), pl);
        check("paddle_r_y", 32'(paddle_r_y), pr);
        check("score_l", 32'(score_l), sl);
        check("score_r", 32'(score_r), sr);
        check("game_over", 32'(game_over), (m_ph == 4) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_ph = 0; bx = 316; by = 236; pl = 216; pr = 216;
        sl = 0; sr = 0; vx = 1; vy = 1; cnt = 0; left_scored = 0;
    endtask

    function automatic int pmove(input int y, input bit u, input bit d);
        if (u && !d) return (y - 4 < 50) ? 50 : y - 4;
        if (d && !u) return (y + 4 > 382) ? 382 : y + 4;
        return y;
    endfunction

    task automatic model_step(input bit t, input bit s, input bit ul, input bit dl,
                              input bit ur, input bit dr);
        int opl, opr, ny;
        bit hl, hr;
        case (m_ph)
            0: if (s) m_ph = 1;
            1: if (t) begin
                pl = pmove(pl, ul, dl);
                pr = pmove(pr, ur, dr);
                if (cnt == 59) begin cnt = 0; m_ph = 2; end
                else cnt++;
            end
            2: if (t) begin
                opl = pl; opr = pr;
                pl = pmove(pl, ul, dl);
                pr = pmove(pr, ur, dr);
                if (vy < 0) begin
                    if (by - 2 < 50) begin ny = 50; vy = 1; end else ny = by - 2;
                end else begin
                    if (by + 10 > 430) begin ny = 422; vy = -1; end else ny = by + 2;
                end
                hl = vx < 0 && bx >= 60 && bx - 2 < 60 && ny + 8 > opl && ny < opl + 48;
                hr = vx > 0 && bx + 8 <= 580 && bx + 10 > 580 && ny + 8 > opr && ny < opr + 48;
                if (hl) begin bx = 60; vx = 1; by = ny; end
                else if (hr) begin bx = 572; vx = -1; by = ny; end
                else if (vx < 0 && bx - 2 < 50) begin m_ph = 3; left_scored = 0; end
                else if (vx > 0 && bx + 10 > 590) begin m_ph = 3; left_scored = 1; end
                else begin bx = bx + 2 * vx; by = ny; end
            end
            3: begin
                if (left_scored) sl++; else sr++;
                if ((left_scored ? sl : sr) == 3) begin
                    m_ph = 4;
                    games++;
                end else begin
                    bx = 316; by = 236;
                    vx = left_scored ? 1 : -1;
                    m_ph = 1;
                end
            end
            4: if (s) begin
                sl = 0; sr = 0; bx = 316; by = 236; pl = 216; pr = 216; vx = 1; m_ph = 1;
            end
            default: ;
        endcase
    endtask

    task automatic step(input bit t, input bit s, input bit ul, input bit dl,
                        input bit ur, input bit dr);
        frame_tick = t; start = s; up_l = ul; dn_l = dl; up_r = ur; dn_r = dr;
        model_step(t, s, ul, dl, ur, dr);
        @(negedge dclk);
        check_all();
    endtask

    task automatic random_step(input int track);
        bit t, s, ul, dl, ur, dr;
        t = ($urandom_range(0, 3) == 0);
        s = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 3) < track) begin
            ul = (by + 4 < pl + 24); dl = (by + 4 > pl + 24);
        end else begin
            ul = 1'($urandom_range(0, 1)); dl = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 3) < track) begin
            ur = (by + 4 < pr + 24); dr = (by + 4 > pr + 24);
        end else begin
            ur = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1));
        end
        step(t, s, ul, dl, ur, dr);
    endtask

    initial begin
        int track;
        bit found;
        model_reset();
        repeat (2) @(negedge dclk);
        check("rst_ball_x", 32'(ball_x), 316);
        check("rst_ball_y", 32'(ball_y), 236);
        check("rst_paddle_l", 32'(paddle_l_y), 216);
        check("rst_paddle_r", 32'(paddle_r_y), 216);
        check("rst_scores", 32'({score_l, score_r}), 0);
        check("rst_game_over", 32'(game_over), 0);
        clr_n = 1'b1;

        // Ticks in IDLE are ignored, then a start coincident with a tick.
        step(1, 0, 1, 0, 0, 1);
        step(1, 1, 1, 0, 0, 1);
        for (int i = 0; i < 61; i++) begin
            step(1, 0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0, 0);
        end
        check("first_move_x", 32'(ball_x), 318);
        check("first_move_y", 32'(ball_y), 238);

        for (int i = 0; i < 60; i++) step(1, 0, 1, 0, 0, 1);
        check("sat_paddle_l", 32'(paddle_l_y), 50);
        check("sat_paddle_r", 32'(paddle_r_y), 382);
        step(1, 0, 1, 1, 1, 1);
        check("conflict_paddle_l", 32'(paddle_l_y), 50);
        check("conflict_paddle_r", 32'(paddle_r_y), 382);

        track = 2;
        for (int i = 0; i < 40000; i++) begin
            if (i % 700 == 0) track = int'($urandom_range(0, 4));
            random_step(track);
        end
        $display("tb_pong_engine: completed games=%0d", games);

        found = 0;
        for (int i = 0; i < 20000 && !found; i++) begin
            if (m_ph == 2 && bx > 200) found = 1;
            else random_step(2);
        end
        assert (found)
        else begin
            failures++;
            $error("FAIL reach_play observed=%0d expected=%0d", m_ph, 2);
        end
        checks++;

        #2 clr_n = 1'b0;
        #1;
        check("clr_ball_x", 32'(ball_x), 316);
        check("clr_ball_y", 32'(ball_y), 236);
        check("clr_paddle_l", 32'(paddle_l_y), 216);
        check("clr_paddle_r", 32'(paddle_r_y), 216);
        check("clr_scores", 32'({score_l, score_r}), 0);
        check("clr_game_over", 32'(game_over), 0);
        model_reset();
        @(negedge dclk);
        clr_n = 1'b1;
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) random_step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
